// File: rtl/frame_playback_reader.sv
// frame_playback_reader: reads a processed frame from RAM (address 0..last) and
// streams it over valid/ready, requesting the next frame once fully drained.
module frame_playback_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_done,
  input  logic [ADDR_WIDTH-1:0] frame_last_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_req,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] last_q, last_nxt, rd_addr_nxt;
  logic                  busy_nxt, frame_req_nxt, overrun_nxt;

  logic                  tag_valid, tag_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;

  logic                  pop, issue, final_hs;
  logic [2:0]            occupancy;

  assign m_valid = (count != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];
  assign pop     = m_valid & m_ready;

  // Credits: entries held plus the read in flight, less the one leaving now.
  assign occupancy = {1'b0, count} + {2'b00, tag_valid} - {2'b00, pop};
  assign final_hs  = (state == DRAIN) & pop & m_last;

  always_comb begin
    state_nxt     = state;
    rd_addr_nxt   = rd_addr;
    last_nxt      = last_q;
    busy_nxt      = busy;
    frame_req_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    issue         = 1'b0;
    case (state)
      IDLE: begin
        if (frame_done) begin
          last_nxt    = frame_last_addr;
          rd_addr_nxt = '0;
          busy_nxt    = 1'b1;
          state_nxt   = READ;
        end
      end
      READ: begin
        overrun_nxt = frame_done;
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (rd_addr == last_q) begin
            state_nxt = DRAIN;
          end else begin
            rd_addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (final_hs) begin
          frame_req_nxt = 1'b1;
          if (frame_done) begin
            // Back-to-back frame: accepted on the very cycle the old one ends.
            last_nxt    = frame_last_addr;
            rd_addr_nxt = '0;
            state_nxt   = READ;
          end else begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          overrun_nxt = frame_done;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      last_q    <= '0;
      busy      <= 1'b0;
      frame_req <= 1'b0;
      overrun   <= 1'b0;
      tag_valid <= 1'b0;
      tag_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= rd_addr_nxt;
      last_q    <= last_nxt;
      busy      <= busy_nxt;
      frame_req <= frame_req_nxt;
      overrun   <= overrun_nxt;
      tag_valid <= issue;
      tag_last  <= issue & (rd_addr == last_q);
    end
  end

  // Two-entry output FIFO; the tag lines up with rd_data one cycle after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
    end else begin
      if (tag_valid) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_last[wr_ptr] <= tag_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, tag_valid} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_frame_playback_reader.sv
// Bench for frame_playback_reader: RAM model plus a queue-based reference of
// expected beats, frame_req/overrun/busy predicted from the frame-level rules.
module tb_frame_playback_reader;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_done = 1'b0;
  logic [AW-1:0] frame_last_addr = '0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          m_valid, m_ready = 1'b0, m_last, busy, frame_req, overrun;
  logic [DW-1:0] m_data;

  frame_playback_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_done(frame_done),
    .frame_last_addr(frame_last_addr), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_req(frame_req), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;

  logic [DW:0]   q[$];
  logic          model_busy = 1'b0, exp_req = 1'b0, exp_ovr = 1'b0;
  logic [AW-1:0] read_last = '0;
  logic          stall_prev = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          s_valid, s_last;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  int            ready_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance the reference, then step past posedge.
  task automatic tick();
    logic          hs, hs_last, n_busy, n_req, n_ovr;
    logic [DW:0]   e;
    if (ready_mode == 1) m_ready = 1'b1;
    else if (ready_mode == 2) m_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    s_valid = m_valid; s_last = m_last; s_addr = rd_addr; s_data = m_data;
    chk("busy", {31'b0, busy}, {31'b0, model_busy});
    chk("frame_req", {31'b0, frame_req}, {31'b0, exp_req});
    chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
    chk("rd_addr_bound", {31'b0, rd_addr <= read_last}, 32'd1);
    if (q.size() == 0) chk("idle_valid", {31'b0, m_valid}, 32'd0);
    if (stall_prev) begin
      chk("hold_data", {16'b0, m_data}, {16'b0, prev_data});
      chk("hold_last", {31'b0, m_last}, {31'b0, prev_last});
    end
    hs = m_valid && m_ready;
    hs_last = 1'b0;
    if (hs) begin
      if (q.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("m_data", {16'b0, m_data}, {16'b0, e[DW-1:0]});
        chk("m_last", {31'b0, m_last}, {31'b0, e[DW]});
        hs_last = e[DW];
      end
    end
    n_req = hs_last;
    n_ovr = 1'b0;
    n_busy = hs_last ? 1'b0 : model_busy;
    if (frame_done) begin
      if (!model_busy || hs_last) begin
        n_busy = 1'b1;
        read_last = frame_last_addr;
        for (int i = 0; i <= int'(frame_last_addr); i++)
          q.push_back({(i == int'(frame_last_addr)), mem[i]});
      end else begin
        n_ovr = 1'b1;
      end
    end
    stall_prev = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    @(posedge clk);
    #1;
    model_busy = n_busy; exp_req = n_req; exp_ovr = n_ovr;
  endtask

  task automatic pulse(input int last);
    frame_done = 1'b1;
    frame_last_addr = AW'(last);
    tick();
    frame_done = 1'b0;
  endtask

  task automatic fill(input int last);
    for (int i = 0; i <= last; i++) mem[i] = DW'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((model_busy || q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) chk("drain_timeout", 32'd0, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    #2;
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_rd_addr", {22'b0, rd_addr}, 32'd0);
    chk("rst_m_data", {16'b0, m_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Directed 4-sample frame, exact cycle timing with m_ready held high.
    mem[0] = 16'h0001; mem[1] = 16'h7FFF; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
    ready_mode = 1;
    pulse(3);
    tick(); chk("t1_rd_addr0", {22'b0, s_addr}, 32'd0);
    tick(); chk("t2_no_valid", {31'b0, s_valid}, 32'd0);
    tick(); chk("t3_valid", {31'b0, s_valid}, 32'd1);
            chk("t3_data", {16'b0, s_data}, 32'h0001);
    tick(); chk("t4_last", {31'b0, s_last}, 32'd0);
    tick(); chk("t5_last", {31'b0, s_last}, 32'd0);
    tick(); chk("t6_last", {31'b0, s_last & s_valid}, 32'd1);
    tick(); chk("t7_no_valid", {31'b0, s_valid}, 32'd0);
    wait_idle(50);

    // Same frame with m_ready pattern 1,0,0,1,0,1 repeated.
    ready_mode = 0;
    frame_done = 1'b1; frame_last_addr = 3;
    m_ready = 1'b1; tick(); frame_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      m_ready = ((k % 6) == 2 || (k % 6) == 4 || (k % 6) == 5);
      tick();
    end
    wait_idle(50);

    // Single-sample frame.
    ready_mode = 1;
    mem[0] = 16'h1234;
    pulse(0);
    wait_idle(50);

    // Overruns: once in READ (stalled), once in DRAIN.
    fill(7);
    ready_mode = 0; m_ready = 1'b0;
    pulse(7);
    tick(); tick();
    pulse(5);
    repeat (6) tick();
    m_ready = 1'b1;
    repeat (7) tick();
    m_ready = 1'b0;
    tick(); tick();
    pulse(2);
    ready_mode = 1;
    wait_idle(50);

    // Frame accepted on the final handshake of the previous one.
    fill(3);
    pulse(3);
    repeat (5) tick();
    fill(1);
    pulse(1);
    tick(); chk("b2b_t1", {31'b0, s_valid}, 32'd0);
    tick(); chk("b2b_t2", {31'b0, s_valid}, 32'd0);
    tick(); chk("b2b_t3", {31'b0, s_valid}, 32'd1);
    wait_idle(50);

    // Random frames under random backpressure.
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      int last;
      last = $urandom_range(4, 40);
      fill(last);
      pulse(last);
      wait_idle(400);
    end

    // Full RAM frame: rd_addr must stop at the top address.
    fill((1 << AW) - 1);
    pulse((1 << AW) - 1);
    wait_idle(5000);
    chk("full_ram_hold", {22'b0, s_addr}, 32'h3FF);

    // Asynchronous reset mid-stream, then a clean frame.
    ready_mode = 1;
    fill(20);
    pulse(20);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("arst_m_data", {16'b0, m_data}, 32'd0);
    chk("arst_m_last", {31'b0, m_last}, 32'd0);
    chk("arst_rd_addr", {22'b0, rd_addr}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_req", {31'b0, frame_req}, 32'd0);
    chk("arst_ovr", {31'b0, overrun}, 32'd0);
    q.delete();
    model_busy = 1'b0; exp_req = 1'b0; exp_ovr = 1'b0; stall_prev = 1'b0;
    read_last = '0;
    tick();
    rst_n = 1'b1;
    tick();
    fill(5);
    pulse(5);
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
